// File: rtl/grf_write_arbiter.sv
// ---------------------------------------------------------------------------
// grf_write_arbiter
//
// Shares the single GRF write port between N_REQ writeback sources using a
// round-robin arbiter. The winning request is registered and presented on
// grf_we/grf_a3/grf_wd one cycle after acceptance. Writes to address 0 still
// complete the handshake and report their source, but never assert grf_we.
//
// Optional feature (macro GRF_WARB_CLEAR_EN): a clear sequencer that, on
// clr_start, writes zero to registers 1..31 on consecutive cycles, with
// clr_busy high for the whole sequence. Without the macro, clr_start is
// ignored and clr_busy is tied low.
//
// Ports:
//   clk        in   clock, posedge active
//   reset      in   asynchronous reset, active low
//   req_valid  in   [N_REQ]      per-source write pending
//   req_addr   in   [N_REQ*AW]   source i address at [i*AW +: AW]
//   req_data   in   [N_REQ*DW]   source i data at [i*DW +: DW]
//   req_ready  out  [N_REQ]      one-hot accept (combinational), or zero
//   clr_start  in   request a clear sequence
//   clr_busy   out  clear sequence in progress
//   grf_we     out  GRF RFen
//   grf_a3     out  [AW]  GRF A3
//   grf_wd     out  [DW]  GRF WD
//   grf_src    out  [N_REQ] one-hot source of the current write, 0 otherwise
// ---------------------------------------------------------------------------
module grf_write_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                grf_we,
  output logic [AW-1:0]       grf_a3,
  output logic [DW-1:0]       grf_wd,
  output logic [N_REQ-1:0]    grf_src
);

  localparam int unsigned PW = (N_REQ > 2) ? 2 : 1;

  // Registered write-port outputs
  logic              r_we;
  logic [AW-1:0]     r_a3;
  logic [DW-1:0]     r_wd;
  logic [N_REQ-1:0]  r_src;
  logic [PW-1:0]     r_rr_ptr;

  // Arbitration wires
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW:0]       w_idx;
  logic [PW-1:0]     w_ptr_nxt;
  logic [N_REQ-1:0]  w_onehot;
  logic [AW-1:0]     w_win_addr;
  logic [DW-1:0]     w_win_data;
  logic              w_arb_open;
  logic              w_grant;

`ifdef GRF_WARB_CLEAR_EN
  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     r_state;
  logic [4:0] r_cnt;
  logic       r_busy;

  // A pending clear request takes priority over every requester
  assign w_arb_open = (r_state == ST_ARB) && !clr_start;
  assign clr_busy   = r_busy;
`else
  logic w_unused_clr;

  assign w_unused_clr = clr_start;
  assign w_arb_open   = 1'b1;
  assign clr_busy     = 1'b0;
`endif

  // Rotating priority search starting at r_rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(off);
      if (w_idx >= (PW+1)'(N_REQ)) begin
        w_idx = w_idx - (PW+1)'(N_REQ);
      end
      if (!w_found && req_valid[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

  assign w_ptr_nxt  = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_onehot   = N_REQ'(1) << w_win;
  assign w_win_addr = req_addr[w_win*AW +: AW];
  assign w_win_data = req_data[w_win*DW +: DW];
  assign w_grant    = w_found && w_arb_open;

  // Gated by reset so nothing is accepted while reset is held
  assign req_ready  = (w_grant && reset) ? w_onehot : '0;

  assign grf_we  = r_we;
  assign grf_a3  = r_a3;
  assign grf_wd  = r_wd;
  assign grf_src = r_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_a3     <= '0;
      r_wd     <= '0;
      r_src    <= '0;
      r_rr_ptr <= '0;
`ifdef GRF_WARB_CLEAR_EN
      r_state  <= ST_ARB;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
`endif
    end else begin
`ifdef GRF_WARB_CLEAR_EN
      // r_cnt tracks the address currently shown on grf_a3; the outputs
      // run one cycle ahead of the state so address k lands in cycle t+k.
      if (r_state == ST_CLEAR) begin
        r_src <= '0;
        r_wd  <= '0;
        if (r_cnt == 5'd31) begin
          r_state <= ST_ARB;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 5'd1;
          r_we  <= 1'b1;
          r_a3  <= AW'(r_cnt + 5'd1);
        end
      end else if (clr_start) begin
        r_state <= ST_CLEAR;
        r_busy  <= 1'b1;
        r_cnt   <= 5'd1;
        r_we    <= 1'b1;
        r_a3    <= AW'(5'd1);
        r_wd    <= '0;
        r_src   <= '0;
      end else
`endif
      if (w_grant) begin
        r_we     <= (w_win_addr != '0);
        r_a3     <= w_win_addr;
        r_wd     <= w_win_data;
        r_src    <= w_onehot;
        r_rr_ptr <= w_ptr_nxt;
      end else begin
        r_we  <= 1'b0;
        r_src <= '0;
      end
    end
  end

endmodule
